// File: rtl/vga_pkg.sv
// Shared timing constants, coordinate width and raster region decode for the
// 640x480 @ 60 Hz video timing path.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 10;

    // Position of a counter within one axis of the raster
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_e;

    // Classify an axis position given the exclusive end of each region
    function automatic region_e region_decode(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] active_end,
        input logic [COORD_W-1:0] fp_end,
        input logic [COORD_W-1:0] sync_end
    );
        region_e r;
        if (pos < active_end) begin
            r = ACTIVE;
        end else if (pos < fp_end) begin
            r = FRONT;
        end else if (pos < sync_end) begin
            r = SYNC;
        end else begin
            r = BACK;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: syncs, active-video qualifier, pixel coordinates and
// line/frame start pulses, shared by the generator and every renderer.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic               hs;
    logic               vs;
    logic               blank;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               line_start;
    logic               frame_start;

    modport master (
        output hs, vs, blank, DrawX, DrawY, line_start, frame_start
    );

    modport slave (
        input  hs, vs, blank, DrawX, DrawY, line_start, frame_start
    );

endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo counter with enable. Resets to MODULUS-1 so the first enabled edge
// after reset lands on 0. Exposes the next count so the owner can register
// decoded flags in step with the count itself.
module vga_wrap_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             tc_s;

    // Terminal-count detect and next-value selection (hold, increment or wrap)
    always_comb begin
        tc_s         = (count_r == LAST);
        count_next_s = count_r;
        if (en) begin
            if (tc_s) begin
                count_next_s = {WIDTH{1'b0}};
            end else begin
                count_next_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register; reset parks it on the last value of the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= LAST;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;
    assign tc         = tc_s;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator. Two wrap counters give the pixel coordinates; all
// sync/qualifier/pulse outputs are registered from the counters' next values
// so every output flop describes the same (DrawX, DrawY) in the same cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vid
);

    localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_FP_END   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_FP_END   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] x_s;
    logic [COORD_W-1:0] y_s;
    logic [COORD_W-1:0] x_next_s;
    logic [COORD_W-1:0] y_next_s;
    logic               h_tc_s;
    logic               v_tc_s;

    region_e            h_region_s;
    region_e            v_region_s;
    logic               blank_next_s;
    logic               hs_next_s;
    logic               vs_next_s;
    logic               line_start_next_s;
    logic               frame_start_next_s;

    logic               hs_r;
    logic               vs_r;
    logic               blank_r;
    logic               line_start_r;
    logic               frame_start_r;

    vga_wrap_counter #(
        .MODULUS (H_LEN),
        .WIDTH   (COORD_W)
    ) u_h_cnt (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (1'b1),
        .count      (x_s),
        .count_next (x_next_s),
        .tc         (h_tc_s)
    );

    vga_wrap_counter #(
        .MODULUS (V_LEN),
        .WIDTH   (COORD_W)
    ) u_v_cnt (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (h_tc_s),
        .count      (y_s),
        .count_next (y_next_s),
        .tc         (v_tc_s)
    );

    // Decode the coordinates that will be presented after the next edge
    always_comb begin
        h_region_s         = region_decode(x_next_s, H_ACT_END, H_FP_END, H_SYNC_END);
        v_region_s         = region_decode(y_next_s, V_ACT_END, V_FP_END, V_SYNC_END);
        blank_next_s       = (h_region_s == ACTIVE) && (v_region_s == ACTIVE);
        hs_next_s          = (h_region_s != SYNC);
        vs_next_s          = (v_region_s != SYNC);
        // x wraps to 0 exactly when the horizontal counter is at its last value
        line_start_next_s  = h_tc_s;
        frame_start_next_s = h_tc_s && v_tc_s;
    end

    // Output flops; reset forces idle syncs and blanking with no pulses
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hs_r          <= hs_next_s;
            vs_r          <= vs_next_s;
            blank_r       <= blank_next_s;
            line_start_r  <= line_start_next_s;
            frame_start_r <= frame_start_next_s;
        end
    end

    assign vid.DrawX       = x_s;
    assign vid.DrawY       = y_s;
    assign vid.hs          = hs_r;
    assign vid.vs          = vs_r;
    assign vid.blank       = blank_r;
    assign vid.line_start  = line_start_r;
    assign vid.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for reset, first
// edge and line-level timing, plus a reduced-geometry instance for frame-level
// wraps, vertical sync and mid-frame reset.
module tb_vga_timing_gen;

    // Reduced geometry: 25 x 17 raster, 425 cycles per frame
    localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
    localparam int S_HT = 25, S_VT = 17, S_FRAME = 425;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    vga_timing_gen_if vid ();
    vga_timing_gen_if vid_s ();

    vga_timing_gen dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .vid     (vid)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) dut_s (
        .vga_clk (clk),
        .reset_n (rst_n),
        .vid     (vid_s)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {blank, hs, vs, line_start, frame_start} for a coordinate
    function automatic logic [4:0] exp_flags(input int x, input int y,
                                             input int ha, input int hf, input int hsw,
                                             input int va, input int vf, input int vsw);
        logic b, h, v, l, f;
        b = (x < ha) && (y < va);
        h = !((x >= ha + hf) && (x < ha + hf + hsw));
        v = !((y >= va + vf) && (y < va + vf + vsw));
        l = (x == 0);
        f = (x == 0) && (y == 0);
        return {b, h, v, l, f};
    endfunction

    function automatic logic [4:0] obs_d();
        return {vid.blank, vid.hs, vid.vs, vid.line_start, vid.frame_start};
    endfunction

    function automatic logic [4:0] obs_s();
        return {vid_s.blank, vid_s.hs, vid_s.vs, vid_s.line_start, vid_s.frame_start};
    endfunction

    initial begin
        int d_seq, d_coh, d_blank, d_hs, d_hs_first, d_hs_last, d_ls, d_ls2;
        int s_seq, s_coh, s_fs, s_gap_bad, s_last_fs, s_blank, s_vs, s_vs_first, s_hs;
        int found;
        n_cmp = 0;
        n_mis = 0;
        d_seq = 0; d_coh = 0; d_blank = 0; d_hs = 0; d_hs_first = -1; d_hs_last = -1;
        d_ls = 0; d_ls2 = -1;
        s_seq = 0; s_coh = 0; s_fs = 0; s_gap_bad = 0; s_last_fs = -1;
        s_blank = 0; s_vs = 0; s_vs_first = -1; s_hs = 0;

        // Reset held for 10 cycles
        rst_n = 1'b0;
        repeat (10) step();
        check_eq("rst_drawx",   32'(vid.DrawX), 32'd799);
        check_eq("rst_drawy",   32'(vid.DrawY), 32'd524);
        check_eq("rst_hs",      32'(vid.hs), 32'd1);
        check_eq("rst_vs",      32'(vid.vs), 32'd1);
        check_eq("rst_blank",   32'(vid.blank), 32'd0);
        check_eq("rst_ls",      32'(vid.line_start), 32'd0);
        check_eq("rst_fs",      32'(vid.frame_start), 32'd0);
        check_eq("rst_s_drawx", 32'(vid_s.DrawX), 32'd24);
        check_eq("rst_s_drawy", 32'(vid_s.DrawY), 32'd16);

        // Release mid-cycle; state index c is the c-th edge after release
        rst_n = 1'b1;
        for (int c = 0; c < 1700; c++) begin
            step();
            if (c == 0) begin
                check_eq("first_drawx", 32'(vid.DrawX), 32'd0);
                check_eq("first_drawy", 32'(vid.DrawY), 32'd0);
                check_eq("first_blank", 32'(vid.blank), 32'd1);
                check_eq("first_ls",    32'(vid.line_start), 32'd1);
                check_eq("first_fs",    32'(vid.frame_start), 32'd1);
            end
            // Full-size instance: coordinates follow the edge count
            if (vid.DrawX !== 10'(c % 800) || vid.DrawY !== 10'(c / 800)) d_seq++;
            if (obs_d() !== exp_flags(int'(vid.DrawX), int'(vid.DrawY), 640, 16, 96, 480, 10, 2)) d_coh++;
            if (c < 800) begin
                if (vid.blank) d_blank++;
                if (!vid.hs) begin
                    d_hs++;
                    if (d_hs_first < 0) d_hs_first = int'(vid.DrawX);
                    d_hs_last = int'(vid.DrawX);
                end
            end
            if (c < 1600 && vid.line_start) begin
                d_ls++;
                if (c > 0) d_ls2 = c;
            end
            // Reduced instance
            if (vid_s.DrawX !== 10'(c % S_HT) || vid_s.DrawY !== 10'((c / S_HT) % S_VT)) s_seq++;
            if (obs_s() !== exp_flags(int'(vid_s.DrawX), int'(vid_s.DrawY), SHA, SHF, SHS, SVA, SVF, SVS)) s_coh++;
            if (vid_s.frame_start) begin
                s_fs++;
                if (s_last_fs >= 0 && (c - s_last_fs) != S_FRAME) s_gap_bad++;
                s_last_fs = c;
            end
            if (c < S_FRAME) begin
                if (vid_s.blank) s_blank++;
                if (!vid_s.vs) begin
                    s_vs++;
                    if (s_vs_first < 0) s_vs_first = c;
                end
            end
            if (c < S_HT && !vid_s.hs) s_hs++;
            if (c == 249) begin
                check_eq("wrap479_x", 32'(vid_s.DrawX), 32'd24);
                check_eq("wrap479_y", 32'(vid_s.DrawY), 32'd9);
            end
            if (c == 250) begin
                check_eq("wrap480_x",     32'(vid_s.DrawX), 32'd0);
                check_eq("wrap480_y",     32'(vid_s.DrawY), 32'd10);
                check_eq("wrap480_blank", 32'(vid_s.blank), 32'd0);
            end
            if (c == 424) begin
                check_eq("wrapend_x", 32'(vid_s.DrawX), 32'd24);
                check_eq("wrapend_y", 32'(vid_s.DrawY), 32'd16);
            end
            if (c == 425) begin
                check_eq("wrap0_x",  32'(vid_s.DrawX), 32'd0);
                check_eq("wrap0_y",  32'(vid_s.DrawY), 32'd0);
                check_eq("wrap0_fs", 32'(vid_s.frame_start), 32'd1);
                check_eq("wrap0_hs", 32'(vid_s.hs), 32'd1);
                check_eq("wrap0_vs", 32'(vid_s.vs), 32'd1);
            end
        end

        check_eq("line_seq_errs",   32'(d_seq), 32'd0);
        check_eq("line_coh_errs",   32'(d_coh), 32'd0);
        check_eq("line_blank_cnt",  32'(d_blank), 32'd640);
        check_eq("line_hs_cnt",     32'(d_hs), 32'd96);
        check_eq("line_hs_first_x", 32'(d_hs_first), 32'd656);
        check_eq("line_hs_last_x",  32'(d_hs_last), 32'd751);
        check_eq("line_ls_cnt",     32'(d_ls), 32'd2);
        check_eq("line_ls2_pos",    32'(d_ls2), 32'd800);
        check_eq("frm_seq_errs",    32'(s_seq), 32'd0);
        check_eq("frm_coh_errs",    32'(s_coh), 32'd0);
        check_eq("frm_fs_cnt",      32'(s_fs), 32'd4);
        check_eq("frm_fs_gap_bad",  32'(s_gap_bad), 32'd0);
        check_eq("frm_blank_cnt",   32'(s_blank), 32'd160);
        check_eq("frm_vs_cnt",      32'(s_vs), 32'd50);
        check_eq("frm_vs_first",    32'(s_vs_first), 32'd300);
        check_eq("frm_hs_cnt",      32'(s_hs), 32'd4);

        // Walk the reduced raster to a point inside both syncs
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            step();
            if (vid_s.DrawX == 10'd20 && vid_s.DrawY == 10'd13) found = 1;
        end
        check_eq("mid_found",  32'(found), 32'd1);
        check_eq("mid_pre_hs", 32'(vid_s.hs), 32'd0);
        check_eq("mid_pre_vs", 32'(vid_s.vs), 32'd0);

        // Asynchronous reset between clock edges
        #5;
        rst_n = 1'b0;
        #1;
        check_eq("mid_hs",      32'(vid_s.hs), 32'd1);
        check_eq("mid_vs",      32'(vid_s.vs), 32'd1);
        check_eq("mid_blank",   32'(vid_s.blank), 32'd0);
        check_eq("mid_drawx",   32'(vid_s.DrawX), 32'd24);
        check_eq("mid_drawy",   32'(vid_s.DrawY), 32'd16);
        check_eq("mid_d_drawx", 32'(vid.DrawX), 32'd799);
        check_eq("mid_d_drawy", 32'(vid.DrawY), 32'd524);
        repeat (3) step();
        rst_n = 1'b1;

        // Restart must be a clean full frame from (0,0)
        s_seq = 0; s_coh = 0; s_fs = 0; s_vs = 0;
        for (int c = 0; c < S_FRAME; c++) begin
            step();
            if (c == 0) begin
                check_eq("restart_x",   32'(vid_s.DrawX), 32'd0);
                check_eq("restart_y",   32'(vid_s.DrawY), 32'd0);
                check_eq("restart_fs",  32'(vid_s.frame_start), 32'd1);
                check_eq("restart_d_x", 32'(vid.DrawX), 32'd0);
                check_eq("restart_d_y", 32'(vid.DrawY), 32'd0);
            end
            if (vid_s.DrawX !== 10'(c % S_HT) || vid_s.DrawY !== 10'(c / S_HT)) s_seq++;
            if (obs_s() !== exp_flags(int'(vid_s.DrawX), int'(vid_s.DrawY), SHA, SHF, SHS, SVA, SVF, SVS)) s_coh++;
            if (vid_s.frame_start) s_fs++;
            if (!vid_s.vs) s_vs++;
        end
        check_eq("restart_seq_errs", 32'(s_seq), 32'd0);
        check_eq("restart_coh_errs", 32'(s_coh), 32'd0);
        check_eq("restart_fs_cnt",   32'(s_fs), 32'd1);
        check_eq("restart_vs_cnt",   32'(s_vs), 32'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
